// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with hold (direct decode) and auto-scan modes.
// Build option: DECODER_SCAN_ACTIVE_LOW_EN makes o active-low (inactive value all ones).
module decoder_scan_n #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        a,
  output logic [(1<<N)-1:0]   o,
  output logic [N-1:0]        sel,
  output logic                wrap,
  output logic [1:0]          state_o
);

  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  SEL_LAST = {N{1'b1}};
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0]  O_OFF = {W{1'b1}};
`else
  localparam logic [W-1:0]  O_OFF = {W{1'b0}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wrap_q, wrap_d;
  logic [W-1:0]   o_q, o_d;
  logic [W-1:0]   onehot_d;

  // Priority inside the case: load beats a mode change, which beats the dwell step.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            state_d = SCAN;
            sel_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
            sel_d   = a;
          end
        end
        HOLD: begin
          if (load) begin
            sel_d = a;
          end else if (mode) begin
            state_d = SCAN;
            sel_d   = '0;
            cnt_d   = '0;
          end
        end
        SCAN: begin
          if (load) begin
            sel_d = a;
            cnt_d = '0;
          end else if (!mode) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            sel_d  = sel_q + 1'b1;
            wrap_d = (sel_q == SEL_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    onehot_d = {{(W-1){1'b0}}, 1'b1} << sel_d;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    o_d = (state_d == IDLE) ? O_OFF : ~onehot_d;
`else
    o_d = (state_d == IDLE) ? O_OFF : onehot_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      o_q     <= O_OFF;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      o_q     <= o_d;
    end
  end

  assign o       = o_q;
  assign sel     = sel_q;
  assign wrap    = wrap_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Randomized + directed bench for decoder_scan_n against a time-based scan model.
module tb_decoder_scan_n;
  localparam int N     = 3;
  localparam int DWELL = 4;
  localparam int W     = 1 << N;

  logic          clk;
  logic          rst, en, mode, load;
  logic [N-1:0]  a;
  logic [W-1:0]  o;
  logic [N-1:0]  sel;
  logic          wrap;
  logic [1:0]    state_o;

  decoder_scan_n #(.N(N), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .a(a),
    .o(o), .sel(sel), .wrap(wrap), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: scan position is derived from the edge count since the scan (re)started.
  int m_cyc = 0, m_on = 0, m_scan = 0, m_idx = 0, m_base = 0, m_t0 = 0;
  int exp_sel = 0;
  logic exp_wrap = 1'b0;
  logic [W-1:0] exp_o;

  function automatic int scan_idx(input int t);
    return (m_base + (t - m_t0) / DWELL) % W;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic m, input logic l, input int av);
    int prev;
    prev = m_cyc;
    m_cyc++;
    exp_wrap = 1'b0;
    if (r) begin
      m_on = 0; m_scan = 0; m_idx = 0;
    end else if (!e) begin
      if (m_on != 0 && m_scan != 0) m_idx = scan_idx(prev);
      m_on = 0; m_scan = 0;
    end else if (m_on == 0) begin
      m_on = 1;
      if (m) begin m_scan = 1; m_base = 0; m_t0 = m_cyc; end
      else begin m_scan = 0; m_idx = av; end
    end else if (l) begin
      if (m_scan != 0) begin m_base = av; m_t0 = m_cyc; end
      else m_idx = av;
    end else if (m_scan != 0 && !m) begin
      m_idx = scan_idx(prev); m_scan = 0;
    end else if (m_scan == 0 && m) begin
      m_scan = 1; m_base = 0; m_t0 = m_cyc;
    end else if (m_scan != 0) begin
      exp_wrap = ((m_cyc - m_t0) % DWELL == 0) && (scan_idx(m_cyc) == 0);
    end
    exp_sel = (m_scan != 0) ? scan_idx(m_cyc) : m_idx;
    exp_o = (m_on != 0) ? (W'(1) << exp_sel) : '0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    exp_o = ~exp_o;
`endif
  endtask

  task automatic cycle(input logic r, input logic e, input logic m, input logic l, input int av);
    logic [W-1:0] act;
    @(negedge clk);
    rst = r; en = e; mode = m; load = l; a = N'(av);
    @(posedge clk);
    model_step(r, e, m, l, av);
    #1;
    check("o", 64'(o), 64'(exp_o));
    check("sel", 64'(sel), 64'(exp_sel));
    check("wrap", 64'(wrap), 64'(exp_wrap));
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    act = ~o;
`else
    act = o;
`endif
    check("onehot", 64'($countones(act) <= 1), 64'(1));
  endtask

  int wraps;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; a = '0;
    repeat (2) cycle(1, 0, 0, 0, 0);
    // direct decode and load
    cycle(0, 1, 0, 0, 5);
    cycle(0, 1, 0, 1, 2);
    cycle(0, 1, 0, 0, 7);
    cycle(0, 1, 0, 0, 7);
    // full sweep from idle; exactly one wrap expected
    cycle(1, 0, 0, 0, 0);
    wraps = 0;
    for (int i = 0; i < DWELL * W + 4; i++) begin
      cycle(0, 1, 1, 0, 0);
      if (i >= 1 && wrap) wraps++;
    end
    check("wrap_count", 64'(wraps), 64'(1));
    // load at sel=3,cnt=3 coincident with dwell step
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * DWELL + DWELL; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 6);
    for (int i = 0; i < DWELL + 1; i++) cycle(0, 1, 1, 0, 0);
    // drop enable mid-scan, re-enable in hold mode
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4 * DWELL + 2; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    // reset mid-scan with other inputs active, then resume
    cycle(1, 1, 1, 1, 3);
    for (int i = 0; i < DWELL + 2; i++) cycle(0, 1, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 92,
            $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 8,
            $urandom_range(0, W - 1));
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered N-to-2^N one-hot decoder with enable and two operating modes: direct decode of a latched address, or autonomous scanning that walks the one-hot output through every line with a programmable dwell time. It drives digit/row strobes for multiplexed displays and keypads, and serves as a general registered select generator wherever the combinational 3-to-8 decoder is too narrow or needs a hold/scan capability.

## Interface
- N, default 3: address width; output width is 2^N (legal 1..6)
- DWELL, default 4: clock cycles each line is held in scan mode (legal ≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  enable; 0 forces all outputs inactive
- mode  input  1  0 = direct decode, 1 = auto-scan
- load  input  1  single-cycle strobe: capture `a` as the current index
- a  input  N  address to decode/jump to
- o  output  2^N  registered one-hot output, bit `sel` active
- sel  output  N  registered current index
- wrap  output  1  one-cycle pulse when a scan wraps from 2^N-1 to 0

## Operation
- States: IDLE, HOLD, SCAN; internal dwell counter `cnt`, width ceil(log2(DWELL)) (min 1).
- Reset: state IDLE, o = all inactive, sel = 0, cnt = 0, wrap = 0.
- Priority per cycle: rst > en=0 > load > mode change > dwell step.
- IDLE: o inactive. en=1, mode=0 → HOLD, sel←a. en=1, mode=1 → SCAN, sel←0, cnt←0. `load` is ignored in IDLE (entry already captures `a` in HOLD).
- HOLD: o = one-hot(sel). load=1 → sel←a. mode=1 → SCAN, sel←0, cnt←0. en=0 → IDLE.
- SCAN: each cycle cnt increments; when cnt = DWELL-1: cnt←0, sel←sel+1 (mod 2^N), wrap←1 iff old sel = 2^N-1. load=1 → sel←a, cnt←0, no wrap. mode=0 → HOLD, sel retained. en=0 → IDLE, sel retained, cnt←0.
- Entry into SCAN never asserts wrap. wrap is 0 in every cycle not described above.
- `sel` and `o` always agree after every edge; o never has more than one active bit.

## Timing
- All outputs registered; one-cycle latency from any sampled input to o/sel/wrap.
- en=1 sampled at edge k (from IDLE, mode=0) → o = one-hot(a) visible after edge k.
- Scan: each index held exactly DWELL cycles; full sweep = DWELL·2^N cycles. DWELL=1 steps every cycle.
- wrap high in the same cycle o first shows index 0 after a wrap.
- load coincident with a dwell step: load wins, cnt restarts at 0.
- en falling mid-dwell: o inactive after the next edge; re-enabling in scan mode restarts at index 0.
- rst mid-operation: reset values after the edge, regardless of other inputs.

## Configuration
- `DECODER_SCAN_ACTIVE_LOW_EN`: when defined, o is active-low (active line 0, others 1; inactive/reset value all ones) for common-anode/low-true strobes. When undefined, o is active-high (reset value all zeros). sel and wrap are unaffected.

## Test plan
- Reset then en=1, mode=0, a=3'b101 → next cycle o=8'b00100000, sel=5, wrap=0; load with a=3'b010 → o=8'b00000100.
- en=1, mode=1, DWELL=4 → o=00000001 for 4 cycles, then 00000010, …; after 32 cycles o=00000001 with wrap high for exactly one cycle.
- In SCAN at sel=3, cnt=3, assert load with a=6 → o=01000000, sel=6, held 4 full cycles, no wrap.
- In SCAN at sel=4, drop en → o=00000000 next cycle; set mode=0 and raise en with a=1 → o=00000010.
- Assert rst mid-scan with en=1, load=1 → o=0, sel=0, wrap=0 after edge; resume scan from index 0.
- With `DECODER_SCAN_ACTIVE_LOW_EN`, N=2, DWELL=1: reset o=4'b1111; scan gives 1110, 1101, 1011, 0111, 1110 (wrap=1).
